// File: rtl/pipelined_add_sub_if.sv
// Operand/result handshake bundle for pipelined_add_sub.
// The master drives operands and consumes results; the slave is the adder.
interface pipelined_add_sub_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, A, B, sel, out_ready,
    input  in_ready, out_valid, S, cout, ovf, zero
  );

  modport slave (
    input  in_valid, A, B, sel, out_ready,
    output in_ready, out_valid, S, cout, ovf, zero
  );
endinterface

// File: rtl/pipelined_add_sub.sv
// Two's-complement adder/subtractor with the carry chain cut into CHUNK-bit pipeline stages.
// Valid/ready at both ends; the whole pipe freezes while the output is stalled.
module pipelined_add_sub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input logic                clk,
  input logic                nrst,
  pipelined_add_sub_if.slave bus
);

  localparam int unsigned STAGES = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
  localparam int unsigned LAST   = STAGES - 1;

  if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $fatal(1, "pipelined_add_sub: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic stall;

  assign stall        = g_stage[LAST].valid_q & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  // Each stage carries the full operands (skew) and the partial sum (deskew) forward;
  // bits that are never consumed downstream are trimmed by synthesis.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             valid_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] sum_in;
    logic             c_in;
    logic [CHUNK:0]   slice;
    logic [WIDTH-1:0] sum_d;

    logic             valid_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;

    if (k == 0) begin : g_first
      assign valid_in = bus.in_valid;
      assign a_in     = bus.A;
      assign b_in     = bus.B ^ {WIDTH{bus.sel}};
      assign c_in     = bus.sel;
      assign sum_in   = '0;
    end else begin : g_rest
      assign valid_in = g_stage[k-1].valid_q;
      assign a_in     = g_stage[k-1].a_q;
      assign b_in     = g_stage[k-1].b_q;
      assign c_in     = g_stage[k-1].carry_q;
      assign sum_in   = g_stage[k-1].sum_q;
    end

    assign slice = {1'b0, a_in[k*CHUNK +: CHUNK]} + {1'b0, b_in[k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, c_in};

    always_comb begin
      sum_d                    = sum_in;
      sum_d[k*CHUNK +: CHUNK]  = slice[CHUNK-1:0];
    end

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        valid_q <= 1'b0;
        a_q     <= '0;
        b_q     <= '0;
        sum_q   <= '0;
        carry_q <= 1'b0;
      end else if (!stall) begin
        valid_q <= valid_in;
        a_q     <= a_in;
        b_q     <= b_in;
        sum_q   <= sum_d;
        carry_q <= slice[CHUNK];
      end
    end
  end

  // Carry into the MSB recovered from the MSB sum bit: c = a ^ b ^ s.
  logic msb_cin;
  logic ovf_d;
  logic zero_d;
  logic ovf_q;
  logic zero_q;

  assign msb_cin = g_stage[LAST].a_in[WIDTH-1] ^ g_stage[LAST].b_in[WIDTH-1]
                 ^ g_stage[LAST].sum_d[WIDTH-1];
  assign ovf_d   = msb_cin ^ g_stage[LAST].slice[CHUNK];
  assign zero_d  = (g_stage[LAST].sum_d == '0);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (!stall) begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign bus.out_valid = g_stage[LAST].valid_q;
  assign bus.S         = g_stage[LAST].sum_q;
  assign bus.cout      = g_stage[LAST].carry_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

  logic unused_skew;
  assign unused_skew = ^{g_stage[LAST].a_q, g_stage[LAST].b_q};

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub (WIDTH=16, CHUNK=4): directed vector table, streaming
// with and without backpressure, and a reset with transactions in flight.
module tb_pipelined_add_sub;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned CHUNK = 4;
  localparam int unsigned NOPS  = 32;

  logic clk = 1'b0;
  logic nrst = 1'b1;
  always #5 clk = ~clk;

  pipelined_add_sub_if #(.WIDTH(WIDTH)) bus ();

  pipelined_add_sub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sel;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t vecs[10];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: {S, cout, ovf, zero}; ovf from the operand/result sign rule.
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic sel);
    logic [15:0] bb;
    logic [16:0] r;
    logic        ov;
    bb = sel ? ~b : b;
    r  = {1'b0, a} + {1'b0, bb} + {16'b0, sel};
    ov = (a[15] == bb[15]) && (r[15] != a[15]);
    return {r[15:0], r[16], ov, (r[15:0] == 16'h0)};
  endfunction

  task automatic run_one(input vec_t v, input string tag);
    int cyc = 0;
    @(negedge clk);
    bus.A         = v.a;
    bus.B         = v.b;
    bus.sel       = v.sel;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      bus.in_valid = 1'b0;
    end while (!bus.out_valid && cyc < 20);
    check({tag, " latency"}, cyc, 4);
    check({tag, " result"}, {bus.S, bus.cout, bus.ovf, bus.zero},
          {v.s, v.cout, v.ovf, v.zero});
  endtask

  task automatic run_stream(input bit stall_mode);
    logic [18:0] exp_q[$];
    logic [18:0] held = '0;
    logic [18:0] got;
    logic [18:0] exp;
    int          sent = 0;
    int          rcvd = 0;
    int          cyc = 0;
    int          first_rx = -1;
    int          last_rx = -1;
    bit          was_stalled = 1'b0;
    bit          pend = 1'b0;
    string       tag = stall_mode ? "stall" : "b2b";
    bus.in_valid = 1'b0;
    while (rcvd < NOPS && cyc < 2000) begin
      @(negedge clk);
      bus.out_ready = stall_mode ? ($urandom_range(0, 99) >= 40) : 1'b1;
      if (!pend && sent < NOPS) begin
        bus.A        = 16'($urandom);
        bus.B        = 16'($urandom);
        bus.sel      = 1'($urandom);
        bus.in_valid = 1'b1;
        pend         = 1'b1;
      end else if (!pend) begin
        bus.in_valid = 1'b0;
      end
      #1;
      got = {bus.S, bus.cout, bus.ovf, bus.zero};
      if (was_stalled) check({tag, " hold"}, {bus.out_valid, got}, {1'b1, held});
      check({tag, " in_ready"}, bus.in_ready, !(bus.out_valid && !bus.out_ready));
      if (bus.out_valid && bus.out_ready) begin
        check({tag, " queue_nonempty"}, exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp = exp_q.pop_front();
          check({tag, " result"}, got, exp);
        end
        rcvd++;
        if (first_rx < 0) first_rx = cyc;
        last_rx = cyc;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.A, bus.B, bus.sel));
        sent++;
        pend = 1'b0;
      end
      was_stalled = bus.out_valid && !bus.out_ready;
      held        = got;
      cyc++;
    end
    check({tag, " count"}, rcvd, NOPS);
    check({tag, " leftover"}, exp_q.size(), 0);
    if (!stall_mode) begin
      check("b2b fill_latency", first_rx, 4);
      check("b2b throughput", last_rx - first_rx, NOPS - 1);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic run_reset_mid();
    bit seen = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.A        = 16'h1111 * 16'(i + 1);
      bus.B        = 16'h0101;
      bus.sel      = 1'b0;
      bus.in_valid = 1'b1;
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("rst pre out_valid", bus.out_valid, 1);
    nrst = 1'b0;
    #1;
    check("rst async out_valid", bus.out_valid, 0);
    check("rst async fields", {bus.S, bus.cout, bus.ovf, bus.zero}, 0);
    check("rst async in_ready", bus.in_ready, 1);
    @(negedge clk);
    @(negedge clk);
    nrst          = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("rst no_stale", seen, 0);
    run_one(vecs[1], "after_rst");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{16'hABCD, 16'hABCD, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};

    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.sel       = 1'b0;
    bus.out_ready = 1'b0;
    #1 nrst = 1'b0;
    #1;
    check("reset out_valid", bus.out_valid, 0);
    check("reset in_ready", bus.in_ready, 1);
    check("reset fields", {bus.S, bus.cout, bus.ovf, bus.zero}, 0);
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;

    for (int i = 0; i < 10; i++) run_one(vecs[i], $sformatf("vec%0d", i));

    run_stream(1'b0);
    run_stream(1'b1);
    run_reset_mid();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
